// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side adapter.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } occ_t;

  localparam int BUF_DEPTH = 2;

  // Number of words held for a given occupancy state.
  function automatic logic [1:0] occ_level(input occ_t s);
    case (s)
      S_EMPTY: return 2'd0;
      S_ONE:   return 2'd1;
      S_TWO:   return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry in-order output buffer: words enter at the tail, the head word
// is kept in a dedicated output register so m_data is a flop output.
module rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output occ_t             o_occ,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  occ_t             r_occ;
  logic             r_hd;
  logic             r_valid;
  logic [WIDTH-1:0] r_dout;
  logic [WIDTH-1:0] r_mem [BUF_DEPTH];
  logic             w_nhd;

  assign w_nhd   = ~r_hd;
  assign o_occ   = r_occ;
  assign o_valid = r_valid;
  assign o_data  = r_dout;

  // Occupancy FSM with storage and head-word output register.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_occ   <= S_EMPTY;
      r_hd    <= 1'b0;
      r_valid <= 1'b0;
      r_dout  <= {WIDTH{1'b0}};
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
    end else if (i_flush) begin
      r_occ   <= S_EMPTY;
      r_valid <= 1'b0;
    end else begin
      case (r_occ)
        S_EMPTY: begin
          if (i_push) begin
            r_mem[r_hd] <= i_data;
            r_dout      <= i_data;
            r_occ       <= S_ONE;
            r_valid     <= 1'b1;
          end
        end
        S_ONE: begin
          if (i_push && i_pop) begin
            // The incoming word lands in the other slot and immediately becomes the head.
            r_mem[w_nhd] <= i_data;
            r_dout       <= i_data;
            r_hd         <= w_nhd;
          end else if (i_push) begin
            r_mem[w_nhd] <= i_data;
            r_occ        <= S_TWO;
          end else if (i_pop) begin
            r_hd    <= w_nhd;
            r_occ   <= S_EMPTY;
            r_valid <= 1'b0;
          end
        end
        S_TWO: begin
          if (i_pop) begin
            r_hd   <= w_nhd;
            r_dout <= r_mem[w_nhd];
            r_occ  <= S_ONE;
          end
        end
        default: begin
          r_occ   <= S_EMPTY;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  rd_skid_buf_chk u_chk (
    .clk     (clk),
    .nrst    (nrst),
    .i_flush (i_flush),
    .i_push  (i_push),
    .i_occ   (r_occ)
  );

endmodule

// File: rtl/rd_skid_buf_chk.sv
// Property checks on the two-entry output buffer.
module rd_skid_buf_chk
  import fifo_rd_pkg::*;
(
  input logic clk,
  input logic nrst,
  input logic i_flush,
  input logic i_push,
  input occ_t i_occ
);

  // A push into a full buffer means the upstream credit logic over-issued reads.
  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (!nrst) !(i_push && !i_flush && (i_occ == S_TWO))
  );

endmodule

// File: rtl/fifo_rd_adapter.sv
// Drains a registered-output FIFO and re-presents its words as a valid/ready
// stream, issuing reads only when the output buffer has room for them.
module fifo_rd_adapter
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               flush,
  input  logic               fifo_valid,
  output logic               fifo_rd_en,
  input  logic [WIDTH-1:0]   fifo_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [WIDTH-1:0]   m_data,
  output logic [COUNT_W-1:0] rd_count
);

  logic               r_infl;
  logic [COUNT_W-1:0] r_count;
  occ_t               w_occ;
  logic               w_valid;
  logic               w_pop;
  logic [2:0]         w_credit;
  logic               w_rd_en;

  assign w_pop      = w_valid && m_ready;
  assign fifo_rd_en = w_rd_en;
  assign m_valid    = w_valid;
  assign rd_count   = r_count;

  // Words held plus the one in flight, after this cycle's pop, must leave room for one more.
  always_comb begin
    w_credit = {1'b0, occ_level(w_occ)} + {2'b00, r_infl} - {2'b00, w_pop};
    if (nrst && !flush && fifo_valid && (w_credit < 3'(BUF_DEPTH))) begin
      w_rd_en = 1'b1;
    end else begin
      w_rd_en = 1'b0;
    end
  end

  // In-flight flag: the FIFO returns data the cycle after a read strobe.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_infl <= 1'b0;
    end else begin
      r_infl <= w_rd_en;
    end
  end

  // Delivered-word counter; survives flush, wraps naturally.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_count <= {COUNT_W{1'b0}};
    end else if (w_pop) begin
      r_count <= r_count + {{(COUNT_W-1){1'b0}}, 1'b1};
    end
  end

  rd_skid_buf #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk     (clk),
    .nrst    (nrst),
    .i_flush (flush),
    .i_push  (r_infl),
    .i_pop   (w_pop),
    .i_data  (fifo_data),
    .o_occ   (w_occ),
    .o_valid (w_valid),
    .o_data  (m_data)
  );

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// Scoreboard bench: a FIFO model feeds two adapter instances (16-bit and 4-bit
// counters); a monitor checks every delivered word against the read order.
module tb_fifo_rd_adapter;

  logic       clk = 1'b0;
  logic       nrst, flush, fifo_valid, m_ready;
  logic [7:0] fifo_data;
  logic       rd_en1, rd_en2, m_valid, m_valid2;
  logic [7:0] m_data, m_data2;
  logic [15:0] rd_count;
  logic [3:0]  rd_count2;

  int n_checks = 0;
  int n_fail   = 0;
  int n_rd     = 0;
  int cnt      = 0;
  int infl_m   = 0;

  logic [7:0] fifo_q [$];
  logic [7:0] exp_q  [$];
  logic [7:0] pend_data;
  logic       have_pend = 1'b0;
  logic [7:0] nxt_word = 8'h00;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic [7:0] mon_w;

  always #5 clk = ~clk;

  fifo_rd_adapter #(.WIDTH(8), .COUNT_W(16)) dut (
    .clk(clk), .nrst(nrst), .flush(flush), .fifo_valid(fifo_valid), .fifo_rd_en(rd_en1),
    .fifo_data(fifo_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .rd_count(rd_count)
  );

  fifo_rd_adapter #(.WIDTH(8), .COUNT_W(4)) dut_c4 (
    .clk(clk), .nrst(nrst), .flush(flush), .fifo_valid(fifo_valid), .fifo_rd_en(rd_en2),
    .fifo_data(fifo_data), .m_valid(m_valid2), .m_ready(m_ready), .m_data(m_data2), .rd_count(rd_count2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic load(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(first + 8'(i));
  endtask

  // One clock cycle: drive at negedge, check strobes at +1, apply flush/reset to the model at +3.
  task automatic step(input logic rdy, input logic fl, input logic gate, input logic rst_n);
    int pend;
    int popn;
    logic e_rd;
    @(negedge clk);
    nrst       = rst_n;
    flush      = fl;
    m_ready    = rdy;
    fifo_data  = have_pend ? pend_data : 8'($urandom);
    have_pend  = 1'b0;
    fifo_valid = gate && (fifo_q.size() > 0);
    #1;
    pend = exp_q.size();
    popn = (m_valid && m_ready) ? 1 : 0;
    e_rd = rst_n && !fl && fifo_valid && ((pend - popn) < 2);
    chk("fifo_rd_en", 32'(rd_en1), 32'(e_rd));
    chk("fifo_rd_en_c4", 32'(rd_en2), 32'(e_rd));
    if (rst_n) begin
      chk("m_valid", 32'(m_valid), 32'((pend - infl_m) > 0));
      chk("m_valid_c4", 32'(m_valid2), 32'((pend - infl_m) > 0));
    end
    if (rd_en1 && (fifo_q.size() > 0)) begin
      pend_data = fifo_q.pop_front();
      exp_q.push_back(pend_data);
      have_pend = 1'b1;
      n_rd++;
    end
    infl_m = rd_en1 ? 1 : 0;
    #2;
    if (fl || !rst_n) begin
      exp_q.delete();
      infl_m = 0;
    end
  endtask

  // Monitor: compares every handshake against the scoreboard queue.
  always begin : monitor
    @(negedge clk);
    #2;
    if (!nrst) begin
      cnt        = 0;
      prev_stall = 1'b0;
    end else begin
      chk("rd_count", 32'(rd_count), 32'(cnt % 65536));
      chk("rd_count_c4", 32'(rd_count2), 32'(cnt % 16));
      if (prev_stall) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", 32'(m_data), 32'(prev_data));
      end
      if (m_valid && m_ready) begin
        chk("word_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          mon_w = exp_q.pop_front();
          chk("m_data", 32'(m_data), 32'(mon_w));
          chk("m_data_c4", 32'(m_data2), 32'(mon_w));
        end
        cnt++;
      end
      prev_stall = m_valid && !m_ready && !flush;
      prev_data  = m_data;
    end
  end

  initial begin
    int snap;
    logic seen;
    nrst = 1'b0; flush = 1'b0; fifo_valid = 1'b0; m_ready = 1'b0; fifo_data = 8'h00;

    // Reset and idle.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("m_data_reset", 32'(m_data), 32'h0);
    chk("m_data_reset_c4", 32'(m_data2), 32'h0);
    chk("rd_count_reset", 32'(rd_count), 32'h0);

    // Full-rate stream of 8 words.
    snap = n_rd;
    load(8'h01, 8);
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("reads_full_rate", 32'(n_rd - snap), 32'd8);
    chk("rd_count_8", 32'(rd_count), 32'd8);

    // Back-pressure: stall 5 cycles after first m_valid.
    load(8'h01, 8);
    seen = 1'b0;
    snap = n_rd;
    for (int i = 0; i < 10 && !seen; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1);
      seen = m_valid;
    end
    chk("first_valid_seen", 32'(seen), 32'd1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("reads_while_stalled", 32'(n_rd - snap), 32'd2);
    chk("stalled_head", 32'(m_data), 32'h01);
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("rd_count_16", 32'(rd_count), 32'd16);

    // Toggling ready.
    load(8'hA0, 4);
    for (int i = 0; i < 14; i++) step((i % 2) == 0, 1'b0, 1'b1, 1'b1);
    chk("rd_count_20", 32'(rd_count), 32'd20);

    // Flush with a full buffer, then flush mid-stream with a word in flight.
    load(8'h10, 16);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("valid_after_flush", 32'(m_valid), 32'd0);
    chk("count_after_flush", 32'(rd_count), 32'd20);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b1, 1'b1);

    // Randomized traffic with occasional flushes.
    nxt_word = 8'($urandom);
    for (int i = 0; i < 600; i++) begin
      if (fifo_q.size() < 4) begin
        load(nxt_word, 6);
        nxt_word = nxt_word + 8'd6;
      end
      step(($urandom % 4) != 0, ($urandom % 40) == 0, ($urandom % 4) != 0, 1'b1);
    end

    // Reset mid-stream, then a 17-word stream to exercise counter wrap.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    fifo_q.delete();
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("valid_after_reset", 32'(m_valid), 32'd0);
    chk("count_after_reset", 32'(rd_count), 32'd0);
    load(8'h40, 17);
    for (int i = 0; i < 24; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("rd_count_17", 32'(rd_count), 32'd17);
    chk("rd_count_c4_wrap", 32'(rd_count2), 32'd1);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
